// File: rtl/boson_frame_gate_pkg.sv
// ============================================================================
//  boson_pkg
//  Shared definitions for the Boson frame gate: capture FSM state encoding,
//  err_o bit positions and the native Boson sensor geometry.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package boson_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    PAD      = 2'd3
  } state_t;

  // Bit positions inside the sticky err_o vector.
  localparam int ERR_SHORT   = 0;
  localparam int ERR_LONG    = 1;
  localparam int ERR_OVERRUN = 2;

  // Native Boson 640 sensor geometry.
  localparam int BOSON_W = 640;
  localparam int BOSON_H = 512;

endpackage : boson_pkg

`default_nettype wire

// File: rtl/boson_vsync_edge.sv
// ============================================================================
//  boson_vsync_edge
//  Registers the camera VSYNC and produces a same-cycle rising-edge strobe.
//
//  Ports
//    clk       in   camera pixel clock
//    rst_n     in   asynchronous active-low reset
//    vsync_i   in   raw frame sync, active high
//    vsync_q   out  vsync_i delayed by one clock
//    sof_edge  out  vsync_i & ~vsync_q (combinational, same cycle as the edge)
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module boson_vsync_edge
  import boson_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic vsync_q,
  output logic sof_edge
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  // The strobe is not registered so that a pixel arriving together with the
  // rising edge can be attributed to the new frame in the same cycle.
  assign sof_edge = vsync_i & ~vsync_q;

endmodule : boson_vsync_edge

`default_nettype wire

// File: rtl/boson_frame_gate.sv
// ============================================================================
//  boson_frame_gate
//  Captures a programmed number of whole, VSYNC-aligned frames from the Boson
//  pixel stream. Every captured frame is delivered as exactly FRAME_PIXELS
//  words: short frames are zero-padded, long frames are truncated.
//
//  Ports
//    clk        in   camera pixel clock
//    rst_n      in   asynchronous active-low reset
//    vsync_i    in   frame sync, frame boundary on its rising edge
//    valid_i    in   pixel qualifier
//    data_i     in   pixel data [DW]
//    arm_i      in   single-cycle capture start request
//    abort_i    in   single-cycle capture cancel request
//    nframes_i  in   frames to capture, sampled on arm [NF_W]
//    m_data_o   out  gated pixel data [DW]
//    m_valid_o  out  gated pixel qualifier (downstream always ready)
//    m_sof_o    out  marks the first word of each captured frame
//    busy_o     out  high whenever the FSM is not IDLE
//    done_o     out  one-cycle pulse when the last requested frame completes
//    frames_o   out  frames completed in the current / last capture [NF_W]
//    err_o      out  sticky {overrun, long, short}
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module boson_frame_gate
  import boson_pkg::*;
#(
  parameter int DW           = 16,
  parameter int FRAME_PIXELS = BOSON_W * BOSON_H,
  parameter int NF_W         = 8,
  parameter int CNT_W        = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vsync_i,
  input  logic            valid_i,
  input  logic [DW-1:0]   data_i,
  input  logic            arm_i,
  input  logic            abort_i,
  input  logic [NF_W-1:0] nframes_i,
  output logic [DW-1:0]   m_data_o,
  output logic            m_valid_o,
  output logic            m_sof_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [NF_W-1:0] frames_o,
  output logic [2:0]      err_o
);

  localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            state;
  logic [NF_W-1:0]   nframes_q;
  logic [CNT_W-1:0]  pix_cnt;

  logic              vsync_q;
  logic              sof_edge;
  logic              unused_vsync_q;

  logic [NF_W-1:0]   frames_inc;
  logic              last_frame;

  // --------------------------------------------------------------------------
  // VSYNC edge detection
  // --------------------------------------------------------------------------
  boson_vsync_edge u_vsync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync_i  (vsync_i),
    .vsync_q  (vsync_q),
    .sof_edge (sof_edge)
  );

  // Only the strobe is needed here; the delayed copy is kept for visibility.
  assign unused_vsync_q = vsync_q;

  // Completing the frame that makes frames_o reach the request ends capture.
  assign frames_inc = frames_o + NF_W'(1);
  assign last_frame = (frames_inc == nframes_q);

  // Derived from the state register, so it is glitch-free and falls the
  // cycle after an abort.
  assign busy_o = (state != IDLE);

  // --------------------------------------------------------------------------
  // Capture FSM with registered output stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      nframes_q <= '0;
      pix_cnt   <= '0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
      m_sof_o   <= 1'b0;
      done_o    <= 1'b0;
      frames_o  <= '0;
      err_o     <= '0;
    end else begin
      // Single-cycle qualifiers default low; m_data_o holds its last value.
      m_valid_o <= 1'b0;
      m_sof_o   <= 1'b0;
      done_o    <= 1'b0;

      if (abort_i) begin
        // No padding and no done pulse. Whatever is already in the output
        // registers still shows for its one cycle.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (arm_i && (nframes_i != '0)) begin
              nframes_q <= nframes_i;
              frames_o  <= '0;
              err_o     <= '0;
              pix_cnt   <= '0;
              state     <= WAIT_SOF;
            end
          end

          WAIT_SOF: begin
            // Pre-sync traffic is dropped; a pixel on the edge opens the frame.
            if (sof_edge) begin
              state   <= CAPTURE;
              pix_cnt <= '0;
              if (valid_i) begin
                m_valid_o <= 1'b1;
                m_sof_o   <= 1'b1;
                m_data_o  <= data_i;
                pix_cnt   <= CNT_ONE;
              end
            end
          end

          CAPTURE: begin
            if (sof_edge) begin
              if (pix_cnt == FRAME_FULL) begin
                // Frame complete; the same edge opens the next frame.
                frames_o <= frames_inc;
                pix_cnt  <= '0;
                if (last_frame) begin
                  done_o <= 1'b1;
                  state  <= IDLE;
                end else if (valid_i) begin
                  m_valid_o <= 1'b1;
                  m_sof_o   <= 1'b1;
                  m_data_o  <= data_i;
                  pix_cnt   <= CNT_ONE;
                end
              end else begin
                // Short frame: the pixel on this edge is lost since the
                // next frame can only start once padding has finished.
                err_o[ERR_SHORT] <= 1'b1;
                state            <= PAD;
              end
            end else if (valid_i) begin
              if (pix_cnt < FRAME_FULL) begin
                m_valid_o <= 1'b1;
                m_sof_o   <= (pix_cnt == '0);
                m_data_o  <= data_i;
                pix_cnt   <= pix_cnt + CNT_ONE;
              end else begin
                err_o[ERR_LONG] <= 1'b1;
              end
            end
          end

          PAD: begin
            // One zero word per cycle; a frame that was entirely empty still
            // gets its start-of-frame marker on the first pad word.
            m_valid_o <= 1'b1;
            m_sof_o   <= (pix_cnt == '0);
            m_data_o  <= '0;
            if (valid_i) begin
              err_o[ERR_OVERRUN] <= 1'b1;
            end
            if (pix_cnt == FRAME_LAST) begin
              frames_o <= frames_inc;
              pix_cnt  <= '0;
              if (last_frame) begin
                done_o <= 1'b1;
                state  <= IDLE;
              end else begin
                // Any edge seen while padding is gone; resync on the next.
                state <= WAIT_SOF;
              end
            end else begin
              pix_cnt <= pix_cnt + CNT_ONE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : boson_frame_gate

`default_nettype wire

// File: tb/tb_boson_frame_gate.sv
// ============================================================================
//  tb_boson_frame_gate
//  Self-checking scoreboard bench for boson_frame_gate with an 8-pixel frame.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_boson_frame_gate;

  localparam int DW    = 16;
  localparam int FP    = 8;
  localparam int NF_W  = 8;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vsync_i;
  logic            valid_i;
  logic [DW-1:0]   data_i;
  logic            arm_i;
  logic            abort_i;
  logic [NF_W-1:0] nframes_i;
  logic [DW-1:0]   m_data_o;
  logic            m_valid_o;
  logic            m_sof_o;
  logic            busy_o;
  logic            done_o;
  logic [NF_W-1:0] frames_o;
  logic [2:0]      err_o;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  // Expected output words: {sof, data}
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  boson_frame_gate #(
    .DW           (DW),
    .FRAME_PIXELS (FP),
    .NF_W         (NF_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_i   (vsync_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .arm_i     (arm_i),
    .abort_i   (abort_i),
    .nframes_i (nframes_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_sof_o   (m_sof_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .frames_o  (frames_o),
    .err_o     (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every valid word must match the head of the queue.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n) begin
      if (m_valid_o) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("word_data", 32'(m_data_o), 32'(e[DW-1:0]));
          check("word_sof", 32'(m_sof_o), 32'(e[DW]));
        end
      end else begin
        check("sof_without_valid", 32'(m_sof_o), 32'd0);
      end
      if (done_o) done_cnt++;
    end
  end

  // One clock of stimulus; optionally records the word the DUT must emit.
  task automatic cyc(input logic vs, input logic v, input logic [DW-1:0] d,
                     input logic exp_word, input logic exp_sof);
    vsync_i = vs;
    valid_i = v;
    data_i  = d;
    if (exp_word) exp_q.push_back({exp_sof, d});
    @(posedge clk);
    #1;
    vsync_i = 1'b0;
    valid_i = 1'b0;
    abort_i = 1'b0;
    arm_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic arm(input logic [NF_W-1:0] n);
    arm_i     = 1'b1;
    nframes_i = n;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    done_cnt  = 0;
  endtask

  // n pixels with data base+1..base+n; the first exp_cnt are expected out.
  task automatic pixels(input int n, input logic [DW-1:0] base, input int exp_cnt,
                        input logic first_sof);
    for (int i = 1; i <= n; i++)
      cyc(1'b0, 1'b1, base + DW'(i), i <= exp_cnt, first_sof && (i == 1));
  endtask

  task automatic pad_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic end_test(input string tag, input int exp_done, input int exp_frames,
                          input logic [2:0] exp_errv);
    idle(12);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_frames"}, 32'(frames_o), 32'(exp_frames));
    check({tag, "_err"}, 32'(err_o), 32'(exp_errv));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    vsync_i   = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    arm_i     = 1'b0;
    abort_i   = 1'b0;
    nframes_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_data", 32'(m_data_o), 32'd0);
    check("rst_sof", 32'(m_sof_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_frames", 32'(frames_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // nframes == 0 is ignored
    arm(8'd0);
    check("arm_zero_busy", 32'(busy_o), 32'd0);

    // Whole frames: two captured, third edge ends the capture
    arm(8'd2);
    check("arm_busy", 32'(busy_o), 32'd1);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      pixels(FP, '0, (f < 2) ? FP : 0, 1'b1);
    end
    end_test("whole", 1, 2, 3'b000);

    // Short frame: 5 pixels, then 3 pad zeros
    arm(8'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pixels(5, '0, 5, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pad_exp(3);
    end_test("short", 1, 1, 3'b001);

    // Long frame: 11 pixels, only 8 forwarded
    arm(8'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pixels(11, 16'h0100, FP, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end_test("long", 1, 1, 3'b010);

    // Overrun: valid traffic while padding
    arm(8'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pixels(5, 16'h0200, 5, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pad_exp(3);
    cyc(1'b0, 1'b1, 16'h0777, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0778, 1'b0, 1'b0);
    end_test("overrun", 1, 1, 3'b101);

    // Pre-sync traffic dropped; pixel on the edge starts the frame
    arm(8'd1);
    pixels(3, 16'h0050, 0, 1'b0);
    cyc(1'b1, 1'b1, 16'h00A1, 1'b1, 1'b1);
    pixels(FP - 1, 16'h00A1, FP - 1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end_test("presync", 1, 1, 3'b000);

    // Abort mid-frame, with a pixel in the abort cycle that must be dropped
    arm(8'd2);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pixels(4, 16'h0300, 4, 1'b1);
    abort_i = 1'b1;
    cyc(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0);
    check("abort_busy", 32'(busy_o), 32'd0);
    end_test("abort", 0, 0, 3'b000);

    // Clean restart after abort
    arm(8'd1);
    cyc(1'b1, 1'b1, 16'h00C1, 1'b1, 1'b1);
    pixels(FP - 1, 16'h00C1, FP - 1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    end_test("restart", 1, 1, 3'b000);

    // Asynchronous reset mid-frame
    arm(8'd1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pixels(2, '0, 2, 1'b1);
    cyc(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid_o), 32'd0);
    check("arst_data", 32'(m_data_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_sof", 32'(m_sof_o), 32'd0);
    check("arst_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check("arst_frames", 32'(frames_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_boson_frame_gate

`default_nettype wire
